// File: rtl/sipo_word_collector.sv
// Serial-in word collector: gathers WIDTH serial bits (MSB- or LSB-first)
// into a word and queues completed words in a small valid/ready FIFO.
// A word that completes while the FIFO is full and not being drained is
// dropped and flagged by the sticky Overrun output.
module sipo_word_collector #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     Bit_valid,
   input  logic                     Din,
   input  logic                     Left,
   input  logic                     Flush,
   output logic [WIDTH-1:0]         Word_out,
   output logic                     Word_valid,
   input  logic                     Word_ready,
   output logic                     Overrun,
   output logic [$clog2(WIDTH):0]   Bit_count,
   output logic                     Busy
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_e;

   state_e           state_q, state_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             dir_eff;
   logic [WIDTH-1:0] shreg_ins;
   logic             push;
   logic [WIDTH-1:0] push_word;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             push_ok;
   logic             drop;

   // Collector next state: Flush beats a bit, the last bit completes a word.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      dir_d     = dir_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_word = '0;
      // Direction is taken live from Left only on the first bit of a word.
      dir_eff   = (state_q == IDLE) ? Left : dir_q;
      shreg_ins = dir_eff ? {shreg_q[WIDTH-2:0], Din} : {Din, shreg_q[WIDTH-1:1]};
      if (Flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         shreg_d = '0;
      end else if (Bit_valid) begin
         dir_d = dir_eff;
         if (cnt_q == LAST_BIT) begin
            push      = 1'b1;
            push_word = shreg_ins;
            shreg_d   = '0;
            cnt_d     = '0;
            state_d   = IDLE;
         end else begin
            shreg_d = shreg_ins;
            cnt_d   = cnt_q + CW'(1);
            state_d = COLLECT;
         end
      end
   end

   // FIFO bookkeeping: the extra pointer MSB separates full from empty.
   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop        = !fifo_empty && Word_ready;
      push_ok    = push && (!fifo_full || pop);
      drop       = push && fifo_full && !pop;
      wr_ptr_d   = wr_ptr_q + PW'(push_ok);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      overrun_d  = overrun_q | drop;
   end

   // State registers with synchronous reset taking priority.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (Rst) begin
         state_q   <= IDLE;
         dir_q     <= 1'b0;
         shreg_q   <= '0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         overrun_q <= overrun_d;
      end
   end

   // FIFO storage write on an accepted push.
   always_ff @(posedge Clk) begin
      // NOTE: storage is not reset; the pointers define validity and Word_out is masked when empty.
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_word;
      end
   end

   // Output decode.
   always_comb begin
      Word_out   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
      Word_valid = !fifo_empty;
      Overrun    = overrun_q;
      Bit_count  = cnt_q;
      Busy       = (state_q == COLLECT);
   end

endmodule

// File: tb/tb_sipo_word_collector.sv
// Directed bench for sipo_word_collector: a per-cycle vector table for the
// collector control corners plus hand-written word-level sequences.
module tb_sipo_word_collector;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Bit_valid = 1'b0;
   logic        Din = 1'b0;
   logic        Left = 1'b1;
   logic        Flush = 1'b0;
   logic        Word_ready = 1'b0;
   logic [15:0] Word_out;
   logic        Word_valid;
   logic        Overrun;
   logic [4:0]  Bit_count;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   sipo_word_collector #(.WIDTH(16), .DEPTH(2)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Bit_valid  (Bit_valid),
      .Din        (Din),
      .Left       (Left),
      .Flush      (Flush),
      .Word_out   (Word_out),
      .Word_valid (Word_valid),
      .Word_ready (Word_ready),
      .Overrun    (Overrun),
      .Bit_count  (Bit_count),
      .Busy       (Busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       rst;
      logic       bv;
      logic       din;
      logic       left;
      logic       flush;
      logic [4:0] e_cnt;
      logic       e_busy;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs are changed 1 time unit after the edge and outputs read there too.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic send_word(input logic [15:0] w, input logic msb, input bit gaps,
                            input bit toggle, input bit ready_last);
      for (int i = 0; i < 16; i++) begin
         Bit_valid  = 1'b1;
         Din        = msb ? w[15-i] : w[i];
         Left       = (toggle && i > 0) ? ~msb : msb;
         Word_ready = ready_last && (i == 15);
         step();
         check("bit_count", 32'(Bit_count), (i + 1) % 16);
         if (gaps) begin
            Bit_valid = 1'b0;
            Din       = ~Din;
            step();
            check("bit_count_gap", 32'(Bit_count), (i + 1) % 16);
         end
      end
      Bit_valid  = 1'b0;
      Word_ready = 1'b0;
      Left       = msb;
   endtask

   task automatic expect_pop(input logic [15:0] exp);
      check("pop_valid", 32'(Word_valid), 1);
      check("pop_word", 32'(Word_out), 32'(exp));
      Word_ready = 1'b1;
      step();
      Word_ready = 1'b0;
   endtask

   task automatic expect_empty();
      check("empty_valid", 32'(Word_valid), 0);
      check("empty_word", 32'(Word_out), 0);
   endtask

   vec_t vecs[8];

   initial begin
      // rst bv din left flush | cnt busy
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0};  // reset
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1};  // first bit
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1};  // gap holds
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1};  // Left change ignored
      vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0};  // Flush beats bit
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1};  // restart
      vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0};  // Rst beats bit
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0};  // idle

      for (int v = 0; v < 8; v++) begin
         Rst       = vecs[v].rst;
         Bit_valid = vecs[v].bv;
         Din       = vecs[v].din;
         Left      = vecs[v].left;
         Flush     = vecs[v].flush;
         step();
         check($sformatf("vec%0d_count", v), 32'(Bit_count), 32'(vecs[v].e_cnt));
         check($sformatf("vec%0d_busy", v), 32'(Busy), 32'(vecs[v].e_busy));
         check($sformatf("vec%0d_valid", v), 32'(Word_valid), 0);
         check($sformatf("vec%0d_word", v), 32'(Word_out), 0);
         check($sformatf("vec%0d_overrun", v), 32'(Overrun), 0);
      end
      Rst = 1'b0; Bit_valid = 1'b0; Flush = 1'b0; Left = 1'b1;

      // MSB-first word, visible right after the 16th bit.
      expect_empty();
      send_word(16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0);
      check("msb_busy_after", 32'(Busy), 0);
      expect_pop(16'hA5C3);
      expect_empty();

      // LSB-first with gaps and Left toggled mid-word.
      send_word(16'h1234, 1'b0, 1'b1, 1'b1, 1'b0);
      expect_pop(16'h1234);
      expect_empty();

      // Overrun: third word dropped while the FIFO is full.
      send_word(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      send_word(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
      check("ovr_before", 32'(Overrun), 0);
      send_word(16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
      check("ovr_after", 32'(Overrun), 1);
      expect_pop(16'h0001);
      expect_pop(16'h0002);
      expect_empty();
      check("ovr_sticky", 32'(Overrun), 1);

      Rst = 1'b1; step(); Rst = 1'b0;
      check("ovr_cleared", 32'(Overrun), 0);

      // Push into a full FIFO while the head is popped in the same cycle.
      send_word(16'h1111, 1'b1, 1'b0, 1'b0, 1'b0);
      send_word(16'h2222, 1'b1, 1'b0, 1'b0, 1'b0);
      check("full_head", 32'(Word_out), 32'h1111);
      send_word(16'h3333, 1'b1, 1'b0, 1'b0, 1'b1);
      check("full_pop_no_ovr", 32'(Overrun), 0);
      expect_pop(16'h2222);
      expect_pop(16'h3333);
      expect_empty();

      // Flush after 7 bits, then a full word of ones.
      for (int i = 0; i < 7; i++) begin
         Bit_valid = 1'b1; Din = 1'b0; Left = 1'b1;
         step();
      end
      check("flush_pre_count", 32'(Bit_count), 7);
      Bit_valid = 1'b0; Flush = 1'b1;
      step();
      Flush = 1'b0;
      check("flush_count", 32'(Bit_count), 0);
      check("flush_busy", 32'(Busy), 0);
      send_word(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_pop(16'hFFFF);
      expect_empty();

      // Reset with one word queued and 9 bits collected.
      send_word(16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         Bit_valid = 1'b1; Din = i[0]; Left = 1'b1;
         step();
      end
      Bit_valid = 1'b0;
      check("rst_pre_count", 32'(Bit_count), 9);
      check("rst_pre_valid", 32'(Word_valid), 1);
      Rst = 1'b1; step(); Rst = 1'b0;
      check("rst_valid", 32'(Word_valid), 0);
      check("rst_count", 32'(Bit_count), 0);
      check("rst_overrun", 32'(Overrun), 0);
      check("rst_busy", 32'(Busy), 0);
      check("rst_word", 32'(Word_out), 0);
      send_word(16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_pop(16'h5A5A);
      expect_empty();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
